// File: rtl/dmi_arbiter_if.sv
// DMI request/response bundle between two debug masters, the arbiter and the debug module.
// The slave modport is the arbiter's view of the bus. The master modport is the surrounding fabric's view.
interface dmi_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int OP_W   = 2
);
  localparam int RQ_W = ADDR_W + DATA_W + OP_W;
  localparam int RS_W = DATA_W + OP_W;

  logic            m0_req_valid;
  logic            m0_req_ready;
  logic [RQ_W-1:0] m0_req_bits;
  logic            m0_resp_valid;
  logic            m0_resp_ready;
  logic [RS_W-1:0] m0_resp_bits;

  logic            m1_req_valid;
  logic            m1_req_ready;
  logic [RQ_W-1:0] m1_req_bits;
  logic            m1_resp_valid;
  logic            m1_resp_ready;
  logic [RS_W-1:0] m1_resp_bits;

  logic            dm_req_valid;
  logic            dm_req_ready;
  logic [RQ_W-1:0] dm_req_bits;
  logic            dm_resp_valid;
  logic            dm_resp_ready;
  logic [RS_W-1:0] dm_resp_bits;

  modport slave (
    input  m0_req_valid, m0_req_bits, m0_resp_ready,
    input  m1_req_valid, m1_req_bits, m1_resp_ready,
    input  dm_req_ready, dm_resp_valid, dm_resp_bits,
    output m0_req_ready, m0_resp_valid, m0_resp_bits,
    output m1_req_ready, m1_resp_valid, m1_resp_bits,
    output dm_req_valid, dm_req_bits, dm_resp_ready
  );

  modport master (
    output m0_req_valid, m0_req_bits, m0_resp_ready,
    output m1_req_valid, m1_req_bits, m1_resp_ready,
    output dm_req_ready, dm_resp_valid, dm_resp_bits,
    input  m0_req_ready, m0_resp_valid, m0_resp_bits,
    input  m1_req_ready, m1_resp_valid, m1_resp_bits,
    input  dm_req_valid, dm_req_bits, dm_resp_ready
  );
endinterface

// File: rtl/dmi_arbiter.sv
// Round-robin sharing of one DMI port between two masters, one transaction in flight.
// Timed-out transactions get an error response, and the late DM reply is later swallowed.
module dmi_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic            sys_clk,
  input  logic            sys_rstn,
  dmi_arbiter_if.slave    bus,
  output logic            busy,
  output logic            timeout_err
);

  localparam int RQ_W = ADDR_W + DATA_W + OP_W;
  localparam int RS_W = DATA_W + OP_W;
  localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TMAX   = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [OP_W-1:0] OP_TMO = OP_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e          state_q;
  logic [RQ_W-1:0] req_q;
  logic [RS_W-1:0] resp_q;
  logic            gnt_q;
  logic            last_grant_q;
  logic            stale_q;
  logic            timeout_err_q;
  logic [TW-1:0]   timer_q;

  logic grant0;
  logic grant1;
  logic is_idle;
  logic timeout_hit;
  logic gnt_resp_ready;

  // On a tie, the master that was not served last wins.
  assign grant0  = bus.m0_req_valid & (~bus.m1_req_valid | last_grant_q);
  assign grant1  = bus.m1_req_valid & (~bus.m0_req_valid | ~last_grant_q);
  assign is_idle = (state_q == ST_IDLE);

  assign bus.m0_req_ready  = sys_rstn & is_idle & grant0;
  assign bus.m1_req_ready  = sys_rstn & is_idle & grant1;

  assign bus.dm_req_valid  = (state_q == ST_REQ);
  assign bus.dm_req_bits   = req_q;
  assign bus.dm_resp_ready = sys_rstn & ((state_q == ST_WAIT) | stale_q);

  assign bus.m0_resp_valid = (state_q == ST_RESP) & ~gnt_q;
  assign bus.m1_resp_valid = (state_q == ST_RESP) &  gnt_q;
  assign bus.m0_resp_bits  = resp_q;
  assign bus.m1_resp_bits  = resp_q;

  assign busy        = ~is_idle;
  assign timeout_err = timeout_err_q;

  assign timeout_hit    = (TIMEOUT != 0) && (timer_q == TMAX);
  assign gnt_resp_ready = gnt_q ? bus.m1_resp_ready : bus.m0_resp_ready;

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      resp_q        <= '0;
      gnt_q         <= 1'b0;
      last_grant_q  <= 1'b1;
      stale_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      timeout_err_q <= 1'b0;

      // A reply to an abandoned transaction may arrive in any state and is discarded.
      if (state_q != ST_WAIT && stale_q && bus.dm_resp_valid) begin
        stale_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            req_q   <= grant0 ? bus.m0_req_bits : bus.m1_req_bits;
            gnt_q   <= grant1;
            state_q <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (bus.dm_req_ready) begin
            timer_q <= '0;
            state_q <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.dm_resp_valid) begin
            if (stale_q) begin
              stale_q <= 1'b0;
            end else begin
              resp_q  <= bus.dm_resp_bits;
              state_q <= ST_RESP;
            end
          end else if (timeout_hit) begin
            resp_q        <= {{DATA_W{1'b0}}, OP_TMO};
            timeout_err_q <= 1'b1;
            stale_q       <= 1'b1;
            state_q       <= ST_RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_RESP: begin
          if (gnt_resp_ready) begin
            last_grant_q <= gnt_q;
            state_q      <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter with TIMEOUT=8.
// Inputs are driven 1 ns after the rising edge, and outputs are checked in that same window.
module tb_dmi_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy;
  logic timeout_err;
  int   n_checks = 0;
  int   n_fails  = 0;

  dmi_arbiter_if #(.ADDR_W(5), .DATA_W(32), .OP_W(2)) bus ();

  dmi_arbiter #(.ADDR_W(5), .DATA_W(32), .OP_W(2), .TIMEOUT(8)) dut (
    .sys_clk     (clk),
    .sys_rstn    (rstn),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_req_valid  = 0; bus.m0_req_bits = '0; bus.m0_resp_ready = 0;
    bus.m1_req_valid  = 0; bus.m1_req_bits = '0; bus.m1_resp_ready = 0;
    bus.dm_req_ready  = 0; bus.dm_resp_valid = 0; bus.dm_resp_bits = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 0;
    tick();
    tick();
    rstn = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 0;
    bus.m0_req_valid = 1;
    bus.m1_req_valid = 1;
    tick();
    n_checks++;
    if ({busy, timeout_err, bus.dm_req_valid, bus.dm_resp_ready} !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_ctrl: busy/tmo/dm_req_valid/dm_resp_ready=%b want 0000",
               {busy, timeout_err, bus.dm_req_valid, bus.dm_resp_ready});
    end
    n_checks++;
    if ({bus.m0_req_ready, bus.m1_req_ready, bus.m0_resp_valid, bus.m1_resp_valid} !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_master: m0rdy/m1rdy/m0rv/m1rv=%b want 0000",
               {bus.m0_req_ready, bus.m1_req_ready, bus.m0_resp_valid, bus.m1_resp_valid});
    end
    clear_inputs();
    rstn = 1;
    tick();
  endtask

  task automatic test_single();
    logic [38:0] rq;
    logic [33:0] rs;
    rq = {5'h10, 32'h0, 2'b01};
    rs = {32'h00000A5A, 2'b00};
    do_reset();
    bus.m0_req_valid = 1;
    bus.m0_req_bits  = rq;
    #1;
    n_checks++;
    if ({bus.m0_req_ready, bus.m1_req_ready} !== 2'b10) begin
      n_fails++;
      $display("FAIL single_grant: m0rdy/m1rdy=%b want 10", {bus.m0_req_ready, bus.m1_req_ready});
    end
    tick();
    bus.m0_req_valid = 0;
    n_checks++;
    if (bus.dm_req_valid !== 1'b1 || bus.dm_req_bits !== rq || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL single_dm_req: valid=%b bits=%h busy=%b want 1 %h 1",
               bus.dm_req_valid, bus.dm_req_bits, busy, rq);
    end
    bus.dm_req_ready = 1;
    tick();
    bus.dm_req_ready = 0;
    n_checks++;
    if ({bus.dm_req_valid, bus.dm_resp_ready} !== 2'b01) begin
      n_fails++;
      $display("FAIL single_wait: dm_req_valid/dm_resp_ready=%b want 01",
               {bus.dm_req_valid, bus.dm_resp_ready});
    end
    tick();
    tick();
    bus.dm_resp_valid = 1;
    bus.dm_resp_bits  = rs;
    tick();
    bus.dm_resp_valid = 0;
    n_checks++;
    if (bus.m0_resp_valid !== 1'b1 || bus.m0_resp_bits !== rs || bus.m1_resp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL single_resp: m0rv=%b bits=%h m1rv=%b want 1 %h 0",
               bus.m0_resp_valid, bus.m0_resp_bits, bus.m1_resp_valid, rs);
    end
    bus.m0_resp_ready = 1;
    tick();
    bus.m0_resp_ready = 0;
    n_checks++;
    if ({bus.m0_resp_valid, busy} !== 2'b00) begin
      n_fails++;
      $display("FAIL single_done: m0rv/busy=%b want 00", {bus.m0_resp_valid, busy});
    end
  endtask

  task automatic test_round_robin();
    logic [38:0] rq0;
    logic [38:0] rq1;
    logic [33:0] rs;
    rq0 = {5'h01, 32'h11111111, 2'b01};
    rq1 = {5'h02, 32'h22222222, 2'b10};
    do_reset();
    bus.m0_req_valid = 1; bus.m0_req_bits = rq0;
    bus.m1_req_valid = 1; bus.m1_req_bits = rq1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({bus.m0_req_ready, bus.m1_req_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fails++;
        $display("FAIL rr_grant%0d: m0rdy/m1rdy=%b want %b", i,
                 {bus.m0_req_ready, bus.m1_req_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      n_checks++;
      if (bus.dm_req_bits !== ((i % 2 == 0) ? rq0 : rq1) || bus.m0_req_ready !== 1'b0 ||
          bus.m1_req_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL rr_req%0d: bits=%h m0rdy=%b m1rdy=%b", i, bus.dm_req_bits,
                 bus.m0_req_ready, bus.m1_req_ready);
      end
      bus.dm_req_ready = 1;
      tick();
      bus.dm_req_ready  = 0;
      rs = {32'(i + 100), 2'b00};
      bus.dm_resp_valid = 1;
      bus.dm_resp_bits  = rs;
      tick();
      bus.dm_resp_valid = 0;
      n_checks++;
      if ({bus.m0_resp_valid, bus.m1_resp_valid} !== ((i % 2 == 0) ? 2'b10 : 2'b01) ||
          ((i % 2 == 0) ? bus.m0_resp_bits : bus.m1_resp_bits) !== rs) begin
        n_fails++;
        $display("FAIL rr_resp%0d: m0rv/m1rv=%b m0bits=%h m1bits=%h want bits %h", i,
                 {bus.m0_resp_valid, bus.m1_resp_valid}, bus.m0_resp_bits, bus.m1_resp_bits, rs);
      end
      if (i % 2 == 0) bus.m0_resp_ready = 1; else bus.m1_resp_ready = 1;
      tick();
      bus.m0_resp_ready = 0;
      bus.m1_resp_ready = 0;
    end
    clear_inputs();
  endtask

  task automatic test_req_stall();
    logic [38:0] rq;
    rq = {5'h07, 32'hCAFEF00D, 2'b10};
    do_reset();
    bus.m0_req_valid = 1; bus.m0_req_bits = rq;
    #1;
    tick();
    bus.m0_req_valid = 0;
    bus.m1_req_valid = 1; bus.m1_req_bits = {5'h1F, 32'h0, 2'b01};
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (bus.dm_req_valid !== 1'b1 || bus.dm_req_bits !== rq || busy !== 1'b1 ||
          bus.m1_req_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL req_stall%0d: valid=%b bits=%h busy=%b m1rdy=%b want 1 %h 1 0", c,
                 bus.dm_req_valid, bus.dm_req_bits, busy, bus.m1_req_ready, rq);
      end
      tick();
    end
    bus.m1_req_valid = 0;
    bus.dm_req_ready = 1;
    tick();
    bus.dm_req_ready  = 0;
    bus.dm_resp_valid = 1; bus.dm_resp_bits = {32'h5, 2'b00};
    tick();
    bus.dm_resp_valid = 0;
    n_checks++;
    if (bus.m0_resp_valid !== 1'b1 || bus.m0_resp_bits !== {32'h5, 2'b00}) begin
      n_fails++;
      $display("FAIL req_stall_resp: m0rv=%b bits=%h want 1 %h", bus.m0_resp_valid,
               bus.m0_resp_bits, {32'h5, 2'b00});
    end
    bus.m0_resp_ready = 1;
    tick();
    bus.m0_resp_ready = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.m0_req_valid = 1; bus.m0_req_bits = {5'h03, 32'h0, 2'b01};
    #1;
    tick();
    bus.m0_req_valid = 0;
    bus.dm_req_ready = 1;
    tick();
    bus.dm_req_ready = 0;
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if ({busy, bus.m0_resp_valid, timeout_err, bus.dm_resp_ready} !== 4'b1001) begin
        n_fails++;
        $display("FAIL tmo_wait%0d: busy/m0rv/tmo/dm_resp_ready=%b want 1001", c,
                 {busy, bus.m0_resp_valid, timeout_err, bus.dm_resp_ready});
      end
      tick();
    end
    n_checks++;
    if (timeout_err !== 1'b1 || bus.m0_resp_valid !== 1'b1 || bus.m0_resp_bits !== {32'h0, 2'b10} ||
        bus.dm_resp_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL tmo_fire: tmo=%b m0rv=%b bits=%h dm_resp_ready=%b want 1 1 %h 1",
               timeout_err, bus.m0_resp_valid, bus.m0_resp_bits, bus.dm_resp_ready, {32'h0, 2'b10});
    end
    bus.m0_resp_ready = 1;
    tick();
    bus.m0_resp_ready = 0;
    n_checks++;
    if ({timeout_err, busy} !== 2'b00) begin
      n_fails++;
      $display("FAIL tmo_pulse: tmo/busy=%b want 00", {timeout_err, busy});
    end
    bus.m1_req_valid = 1; bus.m1_req_bits = {5'h04, 32'h0, 2'b01};
    #1;
    tick();
    bus.m1_req_valid = 0;
    bus.dm_req_ready = 1;
    tick();
    bus.dm_req_ready  = 0;
    bus.dm_resp_valid = 1; bus.dm_resp_bits = {32'hDEADBEEF, 2'b00};
    tick();
    bus.dm_resp_valid = 0;
    n_checks++;
    if ({busy, bus.m1_resp_valid} !== 2'b10) begin
      n_fails++;
      $display("FAIL tmo_stale_drop: busy/m1rv=%b want 10", {busy, bus.m1_resp_valid});
    end
    bus.dm_resp_valid = 1; bus.dm_resp_bits = {32'h00001234, 2'b00};
    tick();
    bus.dm_resp_valid = 0;
    n_checks++;
    if (bus.m1_resp_valid !== 1'b1 || bus.m1_resp_bits !== {32'h00001234, 2'b00} ||
        bus.m0_resp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL tmo_next_resp: m1rv=%b bits=%h m0rv=%b want 1 %h 0", bus.m1_resp_valid,
               bus.m1_resp_bits, bus.m0_resp_valid, {32'h00001234, 2'b00});
    end
    bus.m1_resp_ready = 1;
    tick();
    bus.m1_resp_ready = 0;
    n_checks++;
    if ({busy, bus.dm_resp_ready} !== 2'b00) begin
      n_fails++;
      $display("FAIL tmo_cleanup: busy/dm_resp_ready=%b want 00", {busy, bus.dm_resp_ready});
    end
  endtask

  task automatic test_resp_stall();
    do_reset();
    bus.m0_req_valid = 1; bus.m0_req_bits = {5'h05, 32'h0, 2'b01};
    #1;
    tick();
    bus.m0_req_valid = 0;
    bus.dm_req_ready = 1;
    tick();
    bus.dm_req_ready  = 0;
    bus.dm_resp_valid = 1; bus.dm_resp_bits = {32'h77, 2'b00};
    tick();
    bus.dm_resp_valid = 0;
    bus.m1_req_valid  = 1; bus.m1_req_bits = {5'h06, 32'h0, 2'b01};
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if ({bus.m0_resp_valid, bus.m1_req_ready, bus.m1_resp_valid} !== 3'b100) begin
        n_fails++;
        $display("FAIL resp_stall%0d: m0rv/m1rdy/m1rv=%b want 100", c,
                 {bus.m0_resp_valid, bus.m1_req_ready, bus.m1_resp_valid});
      end
      tick();
    end
    bus.m0_resp_ready = 1;
    tick();
    bus.m0_resp_ready = 0;
    n_checks++;
    if ({bus.m0_resp_valid, bus.m1_req_ready} !== 2'b01) begin
      n_fails++;
      $display("FAIL resp_stall_release: m0rv/m1rdy=%b want 01", {bus.m0_resp_valid, bus.m1_req_ready});
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic [38:0] rq0;
    rq0 = {5'h0A, 32'h0000BEEF, 2'b10};
    do_reset();
    // m0 completes first so that, absent a reset, a tie would go to m1.
    bus.m0_req_valid = 1; bus.m0_req_bits = {5'h08, 32'h0, 2'b01};
    #1;
    tick();
    bus.m0_req_valid = 0;
    bus.dm_req_ready = 1;
    tick();
    bus.dm_req_ready  = 0;
    bus.dm_resp_valid = 1;
    tick();
    bus.dm_resp_valid = 0;
    bus.m0_resp_ready = 1;
    tick();
    bus.m0_resp_ready = 0;
    bus.m1_req_valid  = 1; bus.m1_req_bits = {5'h09, 32'h0, 2'b01};
    #1;
    tick();
    bus.m1_req_valid = 0;
    bus.dm_req_ready = 1;
    tick();
    bus.dm_req_ready = 0;
    rstn = 0;
    tick();
    n_checks++;
    if ({busy, bus.dm_req_valid, bus.dm_resp_ready, bus.m1_resp_valid, timeout_err} !== 5'b00000) begin
      n_fails++;
      $display("FAIL reset_mid: busy/dmrv/dmrr/m1rv/tmo=%b want 00000",
               {busy, bus.dm_req_valid, bus.dm_resp_ready, bus.m1_resp_valid, timeout_err});
    end
    rstn = 1;
    bus.m0_req_valid = 1; bus.m0_req_bits = rq0;
    bus.m1_req_valid = 1; bus.m1_req_bits = {5'h0B, 32'h0, 2'b01};
    #1;
    n_checks++;
    if ({bus.m0_req_ready, bus.m1_req_ready} !== 2'b10) begin
      n_fails++;
      $display("FAIL reset_mid_tie: m0rdy/m1rdy=%b want 10", {bus.m0_req_ready, bus.m1_req_ready});
    end
    tick();
    clear_inputs();
    n_checks++;
    if (bus.dm_req_bits !== rq0 || bus.m1_resp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_mid_req: bits=%h m1rv=%b want %h 0", bus.dm_req_bits, bus.m1_resp_valid, rq0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_req_stall();
    test_timeout();
    test_resp_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
